// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: destination-tag scoreboard for a 5-stage in-order pipeline.
// Tracks the destination of the instructions in EX, MEM and WB. From these tags it
// detects load-use hazards (stall), selects operand forwarding paths and reports
// the registers with pending writes.
// Optional feature: define HAZ_STATS_EN to build a saturating stall-cycle counter;
// otherwise stall_cnt is tied to zero.
module hazard_scoreboard #(
  parameter logic [2:0] NULL_REG = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [2:0]  src_a_addr,
  input  logic [2:0]  src_b_addr,
  input  logic [2:0]  dest_addr,
  input  logic        dest_we,
  input  logic        is_load,
  input  logic        flush,
  output logic        stall,
  output logic        issue_ack,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [6:0]  busy_vec,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [2:0] addr;
    logic       load;
  } tag_t;

  tag_t ex_tag, mem_tag, wb_tag, issue_tag;
  logic use_a, use_b;

  // Returns 1 when src is a real register and matches a valid tag.
  // A load in EX has no result yet, so load_ok=0 rejects it as a forwarding source.
  function automatic logic tag_hit(input logic [2:0] src, input tag_t t, input logic load_ok);
    return (src != NULL_REG) && t.valid && (load_ok || !t.load) && (t.addr == src);
  endfunction

  // Forwarding select: the youngest stage wins.
  function automatic logic [1:0] fwd_sel(input logic [2:0] src, input tag_t ex,
                                         input tag_t mem, input tag_t wb);
    if (tag_hit(src, ex, 1'b0))       return 2'b01;
    else if (tag_hit(src, mem, 1'b1)) return 2'b10;
    else if (tag_hit(src, wb, 1'b1))  return 2'b11;
    else                              return 2'b00;
  endfunction

  // Build the tag that the issuing instruction loads into EX.
  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = dest_we && (dest_addr != NULL_REG);
    issue_tag.addr  = dest_addr;
    issue_tag.load  = is_load;
  end

  // Load-use detection: a flush overrides the stall, so the bubble it inserts is
  // never counted as a stall cycle.
  always_comb begin
    use_a     = (src_a_addr != NULL_REG) && (src_a_addr == ex_tag.addr);
    use_b     = (src_b_addr != NULL_REG) && (src_b_addr == ex_tag.addr);
    stall     = issue_valid && ex_tag.valid && ex_tag.load && (use_a || use_b) && !flush;
    issue_ack = issue_valid && !stall && !flush;
  end

  // Operand forwarding selects. They are driven during a stall as well.
  always_comb begin
    fwd_a_sel = fwd_sel(src_a_addr, ex_tag, mem_tag, wb_tag);
    fwd_b_sel = fwd_sel(src_b_addr, ex_tag, mem_tag, wb_tag);
  end

  // Pending-write map: OR of the one-hot decode of every valid in-flight tag.
  always_comb begin
    busy_vec = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (3'(i) != NULL_REG &&
          ((ex_tag.valid  && ex_tag.addr  == 3'(i)) ||
           (mem_tag.valid && mem_tag.addr == 3'(i)) ||
           (wb_tag.valid  && wb_tag.addr  == 3'(i))))
        busy_vec[i] = 1'b1;
    end
  end

  // Advance the tag pipeline every cycle; a bubble enters EX when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      ex_tag  <= issue_ack ? issue_tag : '0;
    end
  end

`ifdef HAZ_STATS_EN
  logic [15:0] cnt_q;

  // Saturating count of stall cycles since reset.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (stall && cnt_q != '1)
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: a table of per-cycle vectors with hand-derived
// expected outputs, routed through an expectation queue. It is followed by a short
// hand-written load-use sequence that waits for the instruction to be accepted.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  src_a_addr, src_b_addr, dest_addr;
  logic        dest_we, is_load, flush;
  logic        stall, issue_ack;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [6:0]  busy_vec;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard #(.NULL_REG(3'b111)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .dest_addr(dest_addr), .dest_we(dest_we), .is_load(is_load), .flush(flush),
    .stall(stall), .issue_ack(issue_ack),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv;
    logic [2:0] sa, sb, d;
    logic       we, ld, fl;
    logic       st, ack;
    logic [1:0] fa, fb;
    logic [6:0] busy;
  } vec_t;

  typedef struct {
    logic        st, ack;
    logic [1:0]  fa, fb;
    logic [6:0]  busy;
    logic [15:0] cnt;
  } exp_t;

  localparam int NV = 43;
  vec_t vecs [NV];
  exp_t sbq [$];

  function automatic vec_t mk(input int r, input int iv, input int sa, input int sb,
                              input int d, input int we, input int ld, input int fl,
                              input int st, input int ack, input int fa, input int fb,
                              input int busy);
    vec_t v;
    v.rst = 1'(r);  v.iv = 1'(iv); v.sa = 3'(sa); v.sb = 3'(sb); v.d = 3'(d);
    v.we = 1'(we);  v.ld = 1'(ld); v.fl = 1'(fl);
    v.st = 1'(st);  v.ack = 1'(ack); v.fa = 2'(fa); v.fb = 2'(fb); v.busy = 7'(busy);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [2:0] d, input logic we,
                       input logic ld, input logic fl);
    rst = r; issue_valid = iv; src_a_addr = sa; src_b_addr = sb;
    dest_addr = d; dest_we = we; is_load = ld; flush = fl;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_cnt;
    exp_t e, g;
    int stalls;
    logic acked;

    //        rst iv sa sb d we ld fl | st ack fa fb busy
    vecs[0]  = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h00);  // reset state
    vecs[1]  = mk(0,1,7,7,3,1,0,0, 0,1,0,0,'h00);  // ALU dest 3
    vecs[2]  = mk(0,1,3,7,1,0,0,0, 0,1,1,0,'h08);  // src_a=3 from EX
    vecs[3]  = mk(0,1,3,3,1,0,0,0, 0,1,2,2,'h08);  // from MEM
    vecs[4]  = mk(0,1,4,3,1,0,0,0, 0,1,0,3,'h08);  // from WB
    vecs[5]  = mk(0,1,7,7,2,1,1,0, 0,1,0,0,'h00);  // load dest 2
    vecs[6]  = mk(0,1,0,2,4,1,0,0, 1,0,0,0,'h04);  // load-use stall
    vecs[7]  = mk(0,1,0,2,4,1,0,0, 0,1,0,2,'h04);  // reissue, fwd MEM
    vecs[8]  = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h14);
    vecs[9]  = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h10);
    vecs[10] = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h10);
    vecs[11] = mk(0,1,7,7,5,1,0,0, 0,1,0,0,'h00);  // dest 5
    vecs[12] = mk(0,1,7,7,5,1,0,0, 0,1,0,0,'h20);  // dest 5 again
    vecs[13] = mk(0,1,5,7,0,0,0,0, 0,1,1,0,'h20);  // youngest wins
    vecs[14] = mk(0,0,5,7,0,0,0,0, 0,0,2,0,'h20);
    vecs[15] = mk(0,0,5,7,0,0,0,0, 0,0,3,0,'h20);
    vecs[16] = mk(0,0,5,7,0,0,0,0, 0,0,0,0,'h00);  // drained
    vecs[17] = mk(0,1,7,7,7,1,0,0, 0,1,0,0,'h00);  // write to NULL_REG
    vecs[18] = mk(0,1,7,7,0,0,0,0, 0,1,0,0,'h00);
    vecs[19] = mk(0,1,7,7,1,1,1,0, 0,1,0,0,'h00);  // load dest 1
    vecs[20] = mk(0,1,1,7,2,1,0,1, 0,0,0,0,'h02);  // hazard + flush
    vecs[21] = mk(0,0,1,7,0,0,0,0, 0,0,2,0,'h02);  // bubble in EX
    vecs[22] = mk(0,1,7,7,0,0,0,0, 0,1,0,0,'h02);
    vecs[23] = mk(0,1,7,7,3,1,0,1, 0,0,0,0,'h00);  // flush, no hazard
    vecs[24] = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h00);
    vecs[25] = mk(0,1,7,7,6,1,1,0, 0,1,0,0,'h00);  // load dest 6
    vecs[26] = mk(1,1,6,6,0,0,0,0, 1,0,0,0,'h40);  // reset mid-hazard
    vecs[27] = mk(0,1,6,6,0,0,0,0, 0,1,0,0,'h00);  // no stall persists
    vecs[28] = mk(0,1,7,7,1,1,1,0, 0,1,0,0,'h00);  // pair 1
    vecs[29] = mk(0,1,1,7,0,0,0,0, 1,0,0,0,'h02);
    vecs[30] = mk(0,1,1,7,0,0,0,0, 0,1,2,0,'h02);
    vecs[31] = mk(0,1,7,7,2,1,1,0, 0,1,0,0,'h02);  // pair 2
    vecs[32] = mk(0,1,7,2,0,0,0,0, 1,0,0,0,'h04);
    vecs[33] = mk(0,1,7,2,0,0,0,0, 0,1,0,2,'h04);
    vecs[34] = mk(0,1,7,7,3,1,1,0, 0,1,0,0,'h04);  // pair 3
    vecs[35] = mk(0,1,3,3,0,0,0,0, 1,0,0,0,'h08);
    vecs[36] = mk(0,1,3,3,0,0,0,0, 0,1,2,2,'h08);
    vecs[37] = mk(0,1,7,7,4,1,1,0, 0,1,0,0,'h08);  // pair 4
    vecs[38] = mk(0,1,4,7,0,0,0,0, 1,0,0,0,'h10);
    vecs[39] = mk(0,1,4,7,0,0,0,0, 0,1,2,0,'h10);
    vecs[40] = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h10);
    vecs[41] = mk(1,0,7,7,0,0,0,0, 0,0,0,0,'h00);  // reset pulse
    vecs[42] = mk(0,0,7,7,0,0,0,0, 0,0,0,0,'h00);

    drive(1, 0, 7, 7, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    exp_cnt = '0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].iv, vecs[i].sa, vecs[i].sb, vecs[i].d,
            vecs[i].we, vecs[i].ld, vecs[i].fl);
      e.st = vecs[i].st; e.ack = vecs[i].ack; e.fa = vecs[i].fa; e.fb = vecs[i].fb;
      e.busy = vecs[i].busy;
`ifdef HAZ_STATS_EN
      e.cnt = exp_cnt;
`else
      e.cnt = 16'h0000;
`endif
      sbq.push_back(e);
      @(negedge clk);
      g = sbq.pop_front();
      check("stall", i, 16'(stall), 16'(g.st));
      check("issue_ack", i, 16'(issue_ack), 16'(g.ack));
      check("fwd_a_sel", i, 16'(fwd_a_sel), 16'(g.fa));
      check("fwd_b_sel", i, 16'(fwd_b_sel), 16'(g.fb));
      check("busy_vec", i, 16'(busy_vec), 16'(g.busy));
      check("stall_cnt", i, stall_cnt, g.cnt);
      if (vecs[i].rst)
        exp_cnt = '0;
      else if (vecs[i].st && exp_cnt != 16'hFFFF)
        exp_cnt = exp_cnt + 16'd1;
    end

    // Load followed directly by a dependent op: exactly one stall, then a MEM forward.
    @(posedge clk); #1;
    drive(0, 1, 7, 7, 5, 1, 1, 0);
    @(posedge clk); #1;
    drive(0, 1, 5, 7, 0, 0, 0, 0);
    stalls = 0;
    acked = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (issue_ack) begin
        acked = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
    check("seq_ack_seen", 100, 16'(acked), 16'd1);
    check("seq_stall_cycles", 100, 16'(stalls), 16'd1);
    check("seq_fwd_a", 100, 16'(fwd_a_sel), 16'(2'b10));
    @(posedge clk); #1;
    drive(0, 0, 7, 7, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZ_STATS_EN
    check("seq_stall_cnt", 100, stall_cnt, 16'd1);
`else
    check("seq_stall_cnt", 100, stall_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
